// File: rtl/sram_write_arbiter_if.sv
// Write-ownership request/grant bundle between the 16 switch ports and one SRAM arbiter.
interface sram_write_arbiter_if #(
    parameter int unsigned PORT_NUM = 16,
    parameter int unsigned IDX_W    = 4,
    parameter int unsigned CNT_W    = 10
);
    logic [PORT_NUM-1:0] req;
    logic [PORT_NUM-1:0] xfer_vld;
    logic [PORT_NUM-1:0] xfer_eop;
    logic [CNT_W-1:0]    hold_limit;
    logic [PORT_NUM-1:0] grant;
    logic [IDX_W-1:0]    grant_idx;
    logic                grant_vld;
    logic                timeout_err;

    // Port side: raises requests and data beats, observes ownership.
    modport master (
        output req, xfer_vld, xfer_eop, hold_limit,
        input  grant, grant_idx, grant_vld, timeout_err
    );

    // Arbiter side.
    modport slave (
        input  req, xfer_vld, xfer_eop, hold_limit,
        output grant, grant_idx, grant_vld, timeout_err
    );
endinterface

// File: rtl/sram_write_arbiter.sv
// Per-SRAM write arbiter: round-robin grant held until owner eop, with hold watchdog.
module sram_write_arbiter #(
    parameter int unsigned PORT_NUM = 16,
    parameter int unsigned IDX_W    = 4,
    parameter int unsigned CNT_W    = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    sram_write_arbiter_if.slave  bus
);
    typedef enum logic {IDLE, HOLD} state_t;

    state_t              state;
    state_t              state_nxt;
    logic [PORT_NUM-1:0] grant_q,   grant_d;
    logic [IDX_W-1:0]    idx_q,     idx_d;
    logic                vld_q,     vld_d;
    logic                to_q,      to_d;
    logic [IDX_W-1:0]    rr_q,      rr_d;
    logic [CNT_W-1:0]    cnt_q,     cnt_d;

    logic [IDX_W-1:0]    cand;
    logic [IDX_W-1:0]    pick_idx;
    logic                pick_found;
    logic                owner_eop;
    logic                wd_expire;
    logic                release_c;

    // First requesting port at or after rr_q, wrapping around.
    always_comb begin
        pick_idx   = '0;
        pick_found = 1'b0;
        cand       = '0;
        for (int unsigned i = 0; i < PORT_NUM; i++) begin
            cand = IDX_W'((32'(rr_q) + i) % PORT_NUM);
            if (!pick_found && bus.req[cand]) begin
                pick_idx   = cand;
                pick_found = 1'b1;
            end
        end
    end

    // Release causes; eop wins over the watchdog when both hit in one cycle.
    always_comb begin
        owner_eop = bus.xfer_vld[idx_q] & bus.xfer_eop[idx_q];
        wd_expire = (bus.hold_limit != '0) && (cnt_q == (bus.hold_limit - CNT_W'(1)));
        release_c = owner_eop | wd_expire;
    end

    // State register plus registered outputs and bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            grant_q <= '0;
            idx_q   <= '0;
            vld_q   <= 1'b0;
            to_q    <= 1'b0;
            rr_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state   <= state_nxt;
            grant_q <= grant_d;
            idx_q   <= idx_d;
            vld_q   <= vld_d;
            to_q    <= to_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (pick_found) state_nxt = HOLD;
            HOLD: if (release_c)  state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs, round-robin pointer and hold counter.
    always_comb begin
        grant_d = grant_q;
        idx_d   = idx_q;
        vld_d   = vld_q;
        to_d    = 1'b0;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        case (state)
            IDLE: begin
                grant_d = '0;
                idx_d   = '0;
                vld_d   = 1'b0;
                if (pick_found) begin
                    grant_d = PORT_NUM'(1) << pick_idx;
                    idx_d   = pick_idx;
                    vld_d   = 1'b1;
                    cnt_d   = '0;
                end
            end
            HOLD: begin
                if (release_c) begin
                    grant_d = '0;
                    idx_d   = '0;
                    vld_d   = 1'b0;
                    to_d    = ~owner_eop;
                    rr_d    = (idx_q == IDX_W'(PORT_NUM - 1)) ? '0 : idx_q + IDX_W'(1);
                    cnt_d   = '0;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        endcase
    end

    assign bus.grant       = grant_q;
    assign bus.grant_idx   = idx_q;
    assign bus.grant_vld   = vld_q;
    assign bus.timeout_err = to_q;
endmodule

// File: tb/tb_sram_write_arbiter.sv
// Bench for sram_write_arbiter: directed table, corner sequences, randomized model check.
module tb_sram_write_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    sram_write_arbiter_if #(.PORT_NUM(16), .IDX_W(4), .CNT_W(10)) bus ();

    sram_write_arbiter #(.PORT_NUM(16), .IDX_W(4), .CNT_W(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        rst;
        logic [15:0] req;
        logic [15:0] vld;
        logic [15:0] eop;
        logic [15:0] grant;
        logic [3:0]  idx;
        logic        gv;
        logic        to;
    } vec_t;

    vec_t vq[$];
    int   n_cmp = 0;
    int   n_err = 0;
    bit   rand_phase = 1'b0;

    // Reference model: owner as an integer (-1 = free), cycles held, next-in-line port.
    int   m_owner = -1;
    int   m_rr    = 0;
    int   m_cnt   = 0;
    bit   m_to    = 1'b0;

    function automatic logic [21:0] pack(logic to, logic gv, logic [3:0] idx, logic [15:0] g);
        return {to, gv, idx, g};
    endfunction

    function automatic logic [21:0] dut_out();
        return pack(bus.timeout_err, bus.grant_vld, bus.grant_idx, bus.grant);
    endfunction

    function automatic logic [21:0] model_out();
        logic [15:0] g;
        logic [3:0]  ix;
        g  = '0;
        ix = '0;
        if (m_owner >= 0) begin
            g  = 16'(1) << m_owner;
            ix = 4'(m_owner);
        end
        return pack(m_to, m_owner >= 0, ix, g);
    endfunction

    task automatic chk(input string name, input logic [21:0] act, input logic [21:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got to/vld/idx/grant=%h required %h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        logic [15:0] v;
        logic [15:0] e;
        bit          done;
        bit          expired;
        v = bus.xfer_vld;
        e = bus.xfer_eop;
        if (rst) begin
            m_owner = -1;
            m_rr    = 0;
            m_cnt   = 0;
            m_to    = 1'b0;
        end else if (m_owner < 0) begin
            m_to = 1'b0;
            for (int k = 0; k < 16; k++) begin
                if (bus.req[(m_rr + k) % 16]) begin
                    m_owner = (m_rr + k) % 16;
                    m_cnt   = 0;
                    break;
                end
            end
        end else begin
            done    = v[m_owner] && e[m_owner];
            expired = (bus.hold_limit != 0) && (m_cnt == int'(bus.hold_limit) - 1);
            if (done || expired) begin
                m_rr    = (m_owner + 1) % 16;
                m_to    = !done;
                m_owner = -1;
            end else begin
                m_to = 1'b0;
                if (m_cnt < 1023) m_cnt++;
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        if (rand_phase) chk("random", dut_out(), model_out());
    endtask

    task automatic drive(input logic [15:0] r, input logic [15:0] v, input logic [15:0] e);
        bus.req      = r;
        bus.xfer_vld = v;
        bus.xfer_eop = e;
    endtask

    task automatic add(input logic r, input logic [15:0] rq, input logic [15:0] v,
                       input logic [15:0] e, input logic [15:0] g, input logic [3:0] ix,
                       input logic gv, input logic to);
        vec_t t;
        t.rst = r; t.req = rq; t.vld = v; t.eop = e;
        t.grant = g; t.idx = ix; t.gv = gv; t.to = to;
        vq.push_back(t);
    endtask

    initial begin
        drive(16'h0, 16'h0, 16'h0);
        bus.hold_limit = '0;

        // Inputs applied in a cycle, outputs expected after that cycle's edge.
        add(1, 16'h0000, 16'h0000, 16'h0000, 16'h0000,  0, 0, 0);
        add(0, 16'h0001, 16'h0000, 16'h0000, 16'h0001,  0, 1, 0);
        add(0, 16'h0000, 16'h0000, 16'h0000, 16'h0001,  0, 1, 0);
        add(0, 16'h0000, 16'h0001, 16'h0000, 16'h0001,  0, 1, 0);
        add(0, 16'h0000, 16'h0001, 16'h0001, 16'h0000,  0, 0, 0);
        add(0, 16'h8001, 16'h0000, 16'h0000, 16'h8000, 15, 1, 0);
        add(0, 16'h8001, 16'h0001, 16'h0001, 16'h8000, 15, 1, 0);
        add(0, 16'h0001, 16'h8000, 16'h8000, 16'h0000,  0, 0, 0);
        add(0, 16'h0001, 16'h0000, 16'h0000, 16'h0001,  0, 1, 0);
        add(0, 16'h0000, 16'h0001, 16'h0001, 16'h0000,  0, 0, 0);
        add(0, 16'h0084, 16'h0000, 16'h0000, 16'h0004,  2, 1, 0);
        add(0, 16'h0080, 16'h0080, 16'h0080, 16'h0004,  2, 1, 0);
        add(0, 16'h0080, 16'h0004, 16'h0004, 16'h0000,  0, 0, 0);
        add(0, 16'h0080, 16'h0000, 16'h0000, 16'h0080,  7, 1, 0);
        add(0, 16'h0080, 16'h0000, 16'h0000, 16'h0080,  7, 1, 0);
        add(1, 16'h0080, 16'h0000, 16'h0000, 16'h0000,  0, 0, 0);
        add(0, 16'h0011, 16'h0000, 16'h0000, 16'h0001,  0, 1, 0);
        add(0, 16'h0011, 16'h0001, 16'h0001, 16'h0000,  0, 0, 0);
        add(0, 16'h0011, 16'h0000, 16'h0000, 16'h0010,  4, 1, 0);
        add(0, 16'h0000, 16'h0010, 16'h0010, 16'h0000,  0, 0, 0);

        foreach (vq[i]) begin
            rst = vq[i].rst;
            drive(vq[i].req, vq[i].vld, vq[i].eop);
            tick();
            chk($sformatf("vec%0d", i), dut_out(),
                pack(vq[i].to, vq[i].gv, vq[i].idx, vq[i].grant));
        end

        // All ports requesting, 3-beat packets: owners rotate 0..15,0 with one idle cycle between.
        rst = 1'b1; drive(16'h0, 16'h0, 16'h0); tick(); rst = 1'b0;
        bus.req = 16'hFFFF;
        for (int k = 0; k < 17; k++) begin
            logic [15:0] oh;
            oh = 16'(1) << (k % 16);
            tick();
            chk($sformatf("rr_grant%0d", k), dut_out(), pack(0, 1, 4'(k % 16), oh));
            for (int b = 0; b < 3; b++) begin
                bus.xfer_vld = oh;
                bus.xfer_eop = (b == 2) ? oh : 16'h0;
                tick();
                if (b == 2) chk("rr_gap", dut_out(), pack(0, 0, 0, 16'h0));
            end
            drive(16'hFFFF, 16'h0, 16'h0);
        end

        // Watchdog: limit 4, owner 3 stalls; then eop+expiry together, then limit 1.
        rst = 1'b1; drive(16'h0, 16'h0, 16'h0); tick(); rst = 1'b0;
        bus.hold_limit = 10'd4;
        bus.req = 16'h0008;
        tick();
        chk("wd_grant", dut_out(), pack(0, 1, 3, 16'h0008));
        for (int c = 1; c <= 3; c++) begin
            tick();
            chk($sformatf("wd_hold%0d", c), dut_out(), pack(0, 1, 3, 16'h0008));
        end
        bus.req = 16'h0018;
        tick();
        chk("wd_expire", dut_out(), pack(1, 0, 0, 16'h0000));
        tick();
        chk("wd_after", dut_out(), pack(0, 1, 4, 16'h0010));
        bus.hold_limit = 10'd1;
        drive(16'h0008, 16'h0010, 16'h0010);
        tick();
        chk("eop_and_expire", dut_out(), pack(0, 0, 0, 16'h0000));
        drive(16'h0008, 16'h0000, 16'h0000);
        tick();
        chk("lim1_grant", dut_out(), pack(0, 1, 3, 16'h0008));
        tick();
        chk("lim1_expire", dut_out(), pack(1, 0, 0, 16'h0000));

        // Watchdog disabled: a long stall keeps ownership.
        bus.hold_limit = '0;
        drive(16'h0004, 16'h0000, 16'h0000);
        tick();
        for (int c = 0; c < 40; c++) tick();
        chk("no_wd_hold", dut_out(), pack(0, 1, 2, 16'h0004));
        drive(16'h0000, 16'h0004, 16'h0004);
        tick();
        chk("no_wd_release", dut_out(), pack(0, 0, 0, 16'h0000));

        // Randomized traffic against the model.
        rst = 1'b1; drive(16'h0, 16'h0, 16'h0); tick(); rst = 1'b0;
        rand_phase = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            rst          = ($urandom_range(0, 199) == 0);
            bus.req      = 16'($urandom) & 16'($urandom);
            bus.xfer_vld = 16'($urandom);
            bus.xfer_eop = 16'($urandom) & 16'($urandom) & 16'($urandom);
            if ($urandom_range(0, 15) == 0) bus.hold_limit = 10'($urandom_range(0, 12));
            tick();
        end
        rand_phase = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/sram_write_arbiter.md
# sram_write_arbiter

Per-SRAM write-ownership arbiter for the 16-port switch. One instance sits in front of each of the 32 SRAM interfaces. It takes the 16 port requests raised when a port's SRAM matcher selects this SRAM, and grants exclusive write access to exactly one port. Access uses round-robin fairness and is held until that port's end-of-packet beat. A watchdog releases ownership if a packet stalls past a configurable limit.

## Interface
Parameters:
- PORT_NUM, 16, number of requesting write ports
- IDX_W, 4, width of port index (log2 PORT_NUM)
- CNT_W, 10, width of hold watchdog counter

Ports:
- clk  input  1  single clock, all logic rising-edge
- rst  input  1  reset; one clock; reset is synchronous and active-high
- req  input  PORT_NUM  per-port request for write ownership of this SRAM; level, held by requester until granted
- xfer_vld  input  PORT_NUM  per-port data beat valid toward SRAMs
- xfer_eop  input  PORT_NUM  per-port end-of-packet, qualified by xfer_vld
- hold_limit  input  CNT_W  max cycles a grant may be held; 0 disables watchdog
- grant  output  PORT_NUM  one-hot owner select, registered
- grant_idx  output  IDX_W  binary index of owner, valid when grant_vld
- grant_vld  output  1  SRAM currently owned (doubles as occupied flag)
- timeout_err  output  1  one-cycle pulse when watchdog forces release

## Operation
- States: IDLE, HOLD.
- Behaviour in IDLE:
  - If any req bit is set, select the first set bit scanning upward from rr_ptr with wrap (rr_ptr, rr_ptr+1, … 15, 0, …).
  - Register the selection into grant/grant_idx, set grant_vld, go to HOLD, and clear hold_cnt.
  - With no req, remain in IDLE with all outputs 0.
- Behaviour in HOLD:
  - Owner eop (xfer_vld[grant_idx] & xfer_eop[grant_idx]): clear grant/grant_vld/grant_idx next cycle, go to IDLE.
  - Watchdog: hold_cnt increments each HOLD cycle, saturating at all-ones. If hold_limit≠0 and hold_cnt == hold_limit-1 with no owner eop that cycle, release next cycle exactly as for eop, and pulse timeout_err in the release cycle.
  - Owner eop and watchdog expiry in the same cycle: treat as eop; no timeout_err.
- rr_ptr (IDX_W bits): on every release, rr_ptr ← grant_idx+1, wrapping mod PORT_NUM (15→0).
- Deassertion of req by the owner during HOLD is ignored; ownership persists until eop/timeout (packet integrity).
- xfer_vld/xfer_eop from non-owner ports are ignored.
- Owner index is still asserting req after release: it competes normally, but rr_ptr places it last.
- hold_limit is sampled every cycle; a change mid-HOLD takes effect immediately against the current hold_cnt.

## Timing
- Reset (rst high at a clock edge): state=IDLE, grant=0, grant_idx=0, grant_vld=0, timeout_err=0, rr_ptr=0, hold_cnt=0. Reset mid-HOLD drops ownership on that edge without a timeout_err.
- Request-to-grant latency: req seen in IDLE at cycle N → grant at N+1.
- Release latency: owner eop beat at cycle M → grant_vld=0 at M+1 (state IDLE). Earliest next grant at M+2, i.e. a minimum one-cycle gap between owners.
- Watchdog: grant first high at cycle G, hold_limit=L, no eop → grant_vld low at G+L, timeout_err high at G+L only.
- Single-beat packet (eop on first owned beat, cycle G): released at G+1.
- grant, grant_idx and grant_vld are always mutually consistent. grant is one-hot or zero, never multi-hot.

## Test plan
- Reset, then req=16'h0001 at cycle 1 → grant=16'h0001, grant_idx=0, grant_vld=1 at cycle 2. Owner eop at cycle 5 → grant_vld=0 at 6, rr_ptr=1.
- req=16'hFFFF held constantly, each owner sending 3-beat packets → grant_idx sequence 0,1,2,…,15,0 with a one-idle-cycle gap between grants.
- rr_ptr=1 (after granting port 0), req=16'h8001 → port 15 granted first, then port 0 after port 15's eop.
- hold_limit=4, owner port 3 never sends eop, grant at cycle G → grant_vld=0 and timeout_err=1 at G+4, timeout_err=0 at G+5, rr_ptr=4.
- Owner port 2 drops req mid-packet while port 7 sends vld+eop → grant stays 16'h0004. Port 2 eop then releases the grant and port 7 is granted two cycles later.
- rst asserted during HOLD → all outputs 0 on the next edge, no timeout_err. A fresh req=16'h0010 is granted with rr_ptr=0 ordering.
